// File: rtl/stack_engine_pkg.sv
// Shared types for the stack engine: FSM state encoding and the IDLE request decode.
package stack_engine_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH_WR = 2'd1,
        POP_RD  = 2'd2,
        DONE    = 2'd3
    } stack_state_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_LD   = 2'd1,
        OP_PUSH = 2'd2,
        OP_POP  = 2'd3
    } stack_op_e;

    // Load beats push beats pop; lower-priority requests in the same cycle are dropped.
    function automatic stack_op_e decode_op(input logic ld, input logic push, input logic pop);
        stack_op_e op;
        if (ld) begin
            op = OP_LD;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end else begin
            op = OP_NONE;
        end
        return op;
    endfunction

endpackage

// File: rtl/stack_engine_if.sv
// Memory-side req/ack bus between the stack engine (master) and the memory arbiter (slave).
interface stack_engine_if #(
    parameter int unsigned SIZE = 32'd32
);
    logic [SIZE-1:0] mem_addr;
    logic [SIZE-1:0] mem_wdata;
    logic            mem_rd;
    logic            mem_wr;
    logic [SIZE-1:0] mem_rdata;
    logic            mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/stack_engine.sv
// Push/pop sequencer owning the stack pointer; drives the memory bus for stack ops.
// Optional bounds check (refuse push at STACK_LIMIT / pop at STACK_BASE) via `STACK_BOUNDS_CHECK_EN.
module stack_engine
    import stack_engine_pkg::*;
#(
    parameter int unsigned      SIZE        = 32'd32,
    parameter logic [SIZE-1:0]  INITIAL_VAL = '0,
    parameter logic [SIZE-1:0]  STACK_BASE  = '0,
    parameter logic [SIZE-1:0]  STACK_LIMIT = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_ld,
    input  logic [SIZE-1:0] i_push_data,
    input  logic [SIZE-1:0] i_ld_val,
    output logic            o_busy,
    output logic            o_done,
    output logic [SIZE-1:0] o_pop_data,
    output logic            o_fault,
    output logic [SIZE-1:0] o_sp,
    stack_engine_if.master  io_mem
);

`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

    stack_state_e    r_state;
    stack_state_e    w_next_state;
    stack_op_e       w_op;

    logic [SIZE-1:0] r_sp;
    logic [SIZE-1:0] r_pop_data;
    logic [SIZE-1:0] r_mem_addr;
    logic [SIZE-1:0] r_mem_wdata;
    logic            r_mem_rd;
    logic            r_mem_wr;
    logic            r_busy;
    logic            r_done;
    logic            r_fault;

    logic [SIZE-1:0] w_next_sp;
    logic [SIZE-1:0] w_next_pop_data;
    logic [SIZE-1:0] w_next_addr;
    logic [SIZE-1:0] w_next_wdata;
    logic            w_next_fault;
    logic            w_push_blocked;
    logic            w_pop_blocked;

    assign w_push_blocked = BOUNDS_EN && (r_sp == STACK_LIMIT);
    assign w_pop_blocked  = BOUNDS_EN && (r_sp == STACK_BASE);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, SP arithmetic and memory request set-up.
    always_comb begin
        w_next_state    = r_state;
        w_next_sp       = r_sp;
        w_next_pop_data = r_pop_data;
        w_next_addr     = r_mem_addr;
        w_next_wdata    = r_mem_wdata;
        w_next_fault    = 1'b0;
        w_op            = decode_op(i_ld, i_push, i_pop);

        case (r_state)
            IDLE: begin
                case (w_op)
                    OP_LD: begin
                        w_next_sp    = i_ld_val;
                        w_next_state = DONE;
                    end
                    OP_PUSH: begin
                        if (w_push_blocked) begin
                            w_next_fault = 1'b1;
                            w_next_state = DONE;
                        end else begin
                            // Pre-decrement: the write lands at the new SP.
                            w_next_sp    = r_sp - ONE;
                            w_next_addr  = r_sp - ONE;
                            w_next_wdata = i_push_data;
                            w_next_state = PUSH_WR;
                        end
                    end
                    OP_POP: begin
                        if (w_pop_blocked) begin
                            w_next_fault = 1'b1;
                            w_next_state = DONE;
                        end else begin
                            w_next_addr  = r_sp;
                            w_next_state = POP_RD;
                        end
                    end
                    default: begin
                        w_next_state = IDLE;
                    end
                endcase
            end
            PUSH_WR: begin
                if (io_mem.mem_ack) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = PUSH_WR;
                end
            end
            POP_RD: begin
                if (io_mem.mem_ack) begin
                    w_next_pop_data = io_mem.mem_rdata;
                    w_next_sp       = r_sp + ONE;
                    w_next_state    = DONE;
                end else begin
                    w_next_state = POP_RD;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath and registered status/strobe outputs, all derived from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp        <= INITIAL_VAL;
            r_pop_data  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_sp        <= w_next_sp;
            r_pop_data  <= w_next_pop_data;
            r_mem_addr  <= w_next_addr;
            r_mem_wdata <= w_next_wdata;
            r_mem_rd    <= (w_next_state == POP_RD);
            r_mem_wr    <= (w_next_state == PUSH_WR);
            r_busy      <= (w_next_state != IDLE);
            r_done      <= (w_next_state == DONE);
            r_fault     <= w_next_fault;
        end
    end

    assign o_sp             = r_sp;
    assign o_pop_data       = r_pop_data;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_fault          = r_fault;
    assign io_mem.mem_addr  = r_mem_addr;
    assign io_mem.mem_wdata = r_mem_wdata;
    assign io_mem.mem_rd    = r_mem_rd;
    assign io_mem.mem_wr    = r_mem_wr;

endmodule

// File: tb/tb_stack_engine.sv
// Directed, table-driven bench for stack_engine plus hand-written reset sequences.
`timescale 1ns/1ps
module tb_stack_engine;

    localparam logic [31:0] P_INIT  = 32'h0000_0000;
    localparam logic [31:0] P_BASE  = 32'h0000_0100;
    localparam logic [31:0] P_LIMIT = 32'h0000_00F0;

    typedef struct {
        bit          ld;
        bit          push;
        bit          pop;
        logic [31:0] ld_val;
        logic [31:0] push_data;
        logic [31:0] rdata;
        int          wait_n;
        logic [31:0] exp_sp;
        int          exp_kind;   // 0 none, 1 write, 2 read
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_reqcyc;
        int          exp_lat;
        bit          exp_fault;
        logic [31:0] exp_pd;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        push;
    logic        pop;
    logic        ld;
    logic [31:0] push_data;
    logic [31:0] ld_val;
    logic        busy;
    logic        done;
    logic [31:0] pop_data;
    logic        fault;
    logic [31:0] sp;

    int n_tests;
    int n_fail;

    stack_engine_if #(.SIZE(32'd32)) mem_if ();

    stack_engine #(
        .SIZE(32'd32), .INITIAL_VAL(P_INIT), .STACK_BASE(P_BASE), .STACK_LIMIT(P_LIMIT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_push(push), .i_pop(pop), .i_ld(ld),
        .i_push_data(push_data), .i_ld_val(ld_val), .o_busy(busy), .o_done(done),
        .o_pop_data(pop_data), .o_fault(fault), .o_sp(sp), .io_mem(mem_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit l, bit pu, bit po, logic [31:0] lv, logic [31:0] pd,
                                logic [31:0] rd, int w, logic [31:0] esp, int ek,
                                logic [31:0] ea, logic [31:0] ew, int erq, int elat,
                                bit ef, logic [31:0] epd);
        vec_t v;
        v.ld = l; v.push = pu; v.pop = po; v.ld_val = lv; v.push_data = pd; v.rdata = rd;
        v.wait_n = w; v.exp_sp = esp; v.exp_kind = ek; v.exp_addr = ea; v.exp_wdata = ew;
        v.exp_reqcyc = erq; v.exp_lat = elat; v.exp_fault = ef; v.exp_pd = epd;
        return v;
    endfunction

    vec_t vecs[14];

    initial begin
        logic [31:0] pd11;
        int kind, reqcyc, lat, ndone, overlap;
        logic [31:0] addr_seen, wdata_seen;
        bit fault_seen;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; push = 1'b0; pop = 1'b0; ld = 1'b0;
        push_data = 32'h0; ld_val = 32'h0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'h0;

`ifdef STACK_BOUNDS_CHECK_EN
        pd11 = 32'hCAFE_F00D;
`else
        pd11 = 32'h0000_0055;
`endif
        //            ld push pop ld_val        push_data     rdata         w  exp_sp        k  addr          wdata        rq lat f  pop_data
        vecs[0]  = mk(1, 0, 0, 32'h0000_0100, 32'h0,        32'h0,        0, 32'h0000_0100, 0, 32'h0,        32'h0,        0, 1, 0, 32'h0);
        vecs[1]  = mk(0, 1, 0, 32'h0,        32'hDEAD_BEEF, 32'h0,        0, 32'h0000_00FF, 1, 32'h0000_00FF, 32'hDEAD_BEEF, 1, 2, 0, 32'h0);
        vecs[2]  = mk(0, 0, 1, 32'h0,        32'h0,        32'hDEAD_BEEF, 3, 32'h0000_0100, 2, 32'h0000_00FF, 32'h0,        4, 5, 0, 32'hDEAD_BEEF);
        vecs[3]  = mk(1, 1, 1, 32'h0000_0040, 32'h1111_1111, 32'h0,        0, 32'h0000_0040, 0, 32'h0,        32'h0,        0, 1, 0, 32'hDEAD_BEEF);
        vecs[4]  = mk(0, 1, 0, 32'h0,        32'h1234_5678, 32'h0,        1, 32'h0000_003F, 1, 32'h0000_003F, 32'h1234_5678, 2, 3, 0, 32'hDEAD_BEEF);
        vecs[5]  = mk(1, 0, 0, 32'h0000_00F0, 32'h0,        32'h0,        0, 32'h0000_00F0, 0, 32'h0,        32'h0,        0, 1, 0, 32'hDEAD_BEEF);
`ifdef STACK_BOUNDS_CHECK_EN
        vecs[6]  = mk(0, 1, 0, 32'h0,        32'hA5A5_A5A5, 32'h0,        0, 32'h0000_00F0, 0, 32'h0,        32'h0,        0, 1, 1, 32'hDEAD_BEEF);
`else
        vecs[6]  = mk(0, 1, 0, 32'h0,        32'hA5A5_A5A5, 32'h0,        0, 32'h0000_00EF, 1, 32'h0000_00EF, 32'hA5A5_A5A5, 1, 2, 0, 32'hDEAD_BEEF);
`endif
        vecs[7]  = mk(1, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0000_0000, 0, 32'h0,        32'h0,        0, 1, 0, 32'hDEAD_BEEF);
        vecs[8]  = mk(0, 1, 0, 32'h0,        32'h0000_0001, 32'h0,        0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'h0000_0001, 1, 2, 0, 32'hDEAD_BEEF);
        vecs[9]  = mk(0, 0, 1, 32'h0,        32'h0,        32'hCAFE_F00D, 0, 32'h0000_0000, 2, 32'hFFFF_FFFF, 32'h0,        1, 2, 0, 32'hCAFE_F00D);
        vecs[10] = mk(1, 0, 0, 32'h0000_0100, 32'h0,        32'h0,        0, 32'h0000_0100, 0, 32'h0,        32'h0,        0, 1, 0, 32'hCAFE_F00D);
`ifdef STACK_BOUNDS_CHECK_EN
        vecs[11] = mk(0, 0, 1, 32'h0,        32'h0,        32'h0000_0055, 0, 32'h0000_0100, 0, 32'h0,        32'h0,        0, 1, 1, pd11);
`else
        vecs[11] = mk(0, 0, 1, 32'h0,        32'h0,        32'h0000_0055, 0, 32'h0000_0101, 2, 32'h0000_0100, 32'h0,        1, 2, 0, pd11);
`endif
        vecs[12] = mk(1, 0, 0, 32'h0000_0080, 32'h0,        32'h0,        0, 32'h0000_0080, 0, 32'h0,        32'h0,        0, 1, 0, pd11);
        vecs[13] = mk(0, 1, 1, 32'h0,        32'h0000_0077, 32'h0,        2, 32'h0000_007F, 1, 32'h0000_007F, 32'h0000_0077, 3, 4, 0, pd11);

        // Reset held for two cycles.
        repeat (2) @(negedge clk);
        chk("reset_sp", sp, P_INIT);
        chk("reset_pop_data", pop_data, 32'h0);
        chk("reset_strobes", {28'h0, busy, done, fault, mem_if.mem_rd}, 32'h0);
        chk("reset_mem_wr", {31'h0, mem_if.mem_wr}, 32'h0);
        chk("reset_mem_addr", mem_if.mem_addr, 32'h0);
        chk("reset_mem_wdata", mem_if.mem_wdata, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            ld = vecs[i].ld; push = vecs[i].push; pop = vecs[i].pop;
            ld_val = vecs[i].ld_val; push_data = vecs[i].push_data;
            @(negedge clk);
            ld = 1'b0; push = 1'b0; pop = 1'b0;
            kind = 0; reqcyc = 0; lat = 0; ndone = 0; overlap = 0; fault_seen = 1'b0;
            addr_seen = 32'h0; wdata_seen = 32'h0;
            for (int c = 1; c <= vecs[i].wait_n + 5; c++) begin
                if (mem_if.mem_rd && mem_if.mem_wr) overlap++;
                if (mem_if.mem_rd || mem_if.mem_wr) begin
                    reqcyc++;
                    kind = mem_if.mem_wr ? 1 : 2;
                    addr_seen = mem_if.mem_addr;
                    wdata_seen = mem_if.mem_wdata;
                    mem_if.mem_ack = (reqcyc == vecs[i].wait_n + 1);
                    mem_if.mem_rdata = vecs[i].rdata;
                end else begin
                    mem_if.mem_ack = 1'b0;
                end
                if (done) begin
                    ndone++;
                    lat = c;
                    fault_seen = fault;
                end
                @(negedge clk);
            end
            mem_if.mem_ack = 1'b0;
            chk($sformatf("v%0d_sp", i), sp, vecs[i].exp_sp);
            chk($sformatf("v%0d_pop_data", i), pop_data, vecs[i].exp_pd);
            chk($sformatf("v%0d_done_count", i), ndone, 32'd1);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_fault", i), {31'h0, fault_seen}, {31'h0, vecs[i].exp_fault});
            chk($sformatf("v%0d_access_kind", i), kind, vecs[i].exp_kind);
            chk($sformatf("v%0d_req_cycles", i), reqcyc, vecs[i].exp_reqcyc);
            chk($sformatf("v%0d_rd_wr_overlap", i), overlap, 32'd0);
            if (vecs[i].exp_kind != 0) chk($sformatf("v%0d_mem_addr", i), addr_seen, vecs[i].exp_addr);
            if (vecs[i].exp_kind == 1) chk($sformatf("v%0d_mem_wdata", i), wdata_seen, vecs[i].exp_wdata);
        end

        // Reset while a push waits for its ack; a late ack must be ignored.
        @(negedge clk);
        push = 1'b1; push_data = 32'h0000_0099;
        @(negedge clk);
        push = 1'b0;
        chk("abort_mem_wr_active", {31'h0, mem_if.mem_wr}, 32'h1);
        chk("abort_busy_active", {31'h0, busy}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_mem_wr_dropped", {31'h0, mem_if.mem_wr}, 32'h0);
        chk("abort_sp_reset", sp, P_INIT);
        mem_if.mem_ack = 1'b1;
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("abort_quiet_%0d", c), {29'h0, done, busy, mem_if.mem_wr}, 32'h0);
            @(negedge clk);
        end
        chk("abort_sp_after_late_ack", sp, P_INIT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
